// File: rtl/ysyx_22041211_pkg.sv
// Shared helpers for the ysyx_22041211 core: ceiling log2 and the
// channel-index width rule used by the arbitration blocks.
package ysyx_22041211_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Index width never collapses to zero bits, even for a single channel.
  function automatic int unsigned ch_w(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/ysyx_22041211_rr_pick.sv
// Combinational channel picker: round-robin search starting after base_i,
// or fixed priority (lowest index) when mode_i is low.
module ysyx_22041211_rr_pick
  import ysyx_22041211_pkg::*;
#(
  parameter  int unsigned CH_NUM = 2,
  localparam int unsigned CH_W   = ch_w(CH_NUM)
) (
  input  logic [CH_NUM-1:0] req_i,
  input  logic [CH_W-1:0]   base_i,
  input  logic              mode_i,
  output logic [CH_W-1:0]   grant_o,
  output logic              any_req_o
);

  always_comb begin
    logic              found;
    int unsigned       idx;
    logic [CH_NUM-1:0] req_sh;
    found   = 1'b0;
    idx     = 0;
    req_sh  = '0;
    grant_o = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      idx    = mode_i ? ((32'(base_i) + 1 + i) % CH_NUM) : i;
      req_sh = req_i >> idx;
      if (!found && req_sh[0]) begin
        found   = 1'b1;
        grant_o = CH_W'(idx);
      end
    end
    any_req_o = |req_i;
  end

endmodule

// File: rtl/ysyx_22041211_arb_mux.sv
// N-channel arbitrated selector with a one-entry registered output.
// Holds the winning payload until the downstream stage accepts it.
module ysyx_22041211_arb_mux
  import ysyx_22041211_pkg::*;
#(
  parameter  int unsigned DATA_LEN = 32,
  parameter  int unsigned CH_NUM   = 2,
  parameter  bit          RR_MODE  = 1'b1,
  localparam int unsigned CH_W     = ch_w(CH_NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [CH_NUM-1:0]          in_valid,
  input  logic [CH_NUM*DATA_LEN-1:0] in_data,
  output logic [CH_NUM-1:0]          in_ready,
  output logic                       out_valid,
  output logic [DATA_LEN-1:0]        out_data,
  output logic [CH_W-1:0]            out_ch,
  input  logic                       out_ready
);

  logic                out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0] out_data_q,  out_data_d;
  logic [CH_W-1:0]     out_ch_q,    out_ch_d;
  logic [CH_W-1:0]     ptr_q,       ptr_d;
  logic [CH_W-1:0]     grant;
  logic                any_req;
  logic                can_load;
  logic                load;
  logic [DATA_LEN-1:0] sel_data;

  ysyx_22041211_rr_pick #(
    .CH_NUM (CH_NUM)
  ) u_pick (
    .req_i     (in_valid),
    .base_i    (ptr_q),
    .mode_i    (RR_MODE),
    .grant_o   (grant),
    .any_req_o (any_req)
  );

  assign can_load = !flush && (!out_valid_q || out_ready);
  assign load     = can_load && any_req;
  assign sel_data = DATA_LEN'(in_data >> (32'(grant) * DATA_LEN));

  // rst_n gates the grant so no producer sees a handshake while in reset.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      in_ready[i] = load && rst_n && (grant == CH_W'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = grant;
      if (RR_MODE) ptr_d = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= CH_W'(CH_NUM - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_ysyx_22041211_arb_mux.sv
// Scoreboard bench: three configurations (4ch RR, 4ch fixed, 2ch RR) driven
// with directed and random traffic against a spec-level reference model.
module tb_ysyx_22041211_arb_mux;

  logic clk;
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int N   = (g == 2) ? 2 : 4;
    localparam int RR  = (g == 1) ? 0 : 1;
    localparam int CHW = (N == 2) ? 1 : 2;

    logic              rst_n, flush, out_ready, out_valid;
    logic [N-1:0]      in_valid, in_ready;
    logic [N*32-1:0]   in_data;
    logic [31:0]       out_data;
    logic [CHW-1:0]    out_ch;

    logic [39:0] exp_q[$];
    logic [31:0] dat[4];
    int          pushed = 0;
    int          acc_ch = -1;
    int          m_ptr;
    bit          m_held;
    bit          done = 0;

    ysyx_22041211_arb_mux #(
      .DATA_LEN (32),
      .CH_NUM   (N),
      .RR_MODE  (RR[0])
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", g, nm, act, exp, $time);
      end
    endtask

    // Reference grant: first requester after ptr (RR) or lowest requester.
    function automatic int pick(input logic [3:0] v, input int p);
      if (RR != 0) begin
        for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
      end else begin
        for (int c = 0; c < N; c++) if (v[c]) return c;
      end
      return -1;
    endfunction

    task automatic drive_data();
      for (int c = 0; c < N; c++) in_data[c*32 +: 32] = dat[c];
    endtask

    task automatic cyc(input logic [3:0] v, input bit ordy, input bit fl);
      int         gr;
      bit         can;
      logic [3:0] er;
      @(negedge clk);
      if (acc_ch >= 0) begin
        dat[acc_ch] = $urandom;
        acc_ch = -1;
      end
      in_valid  = v[N-1:0];
      out_ready = ordy;
      flush     = fl;
      drive_data();
      #1;
      gr  = pick(v, m_ptr);
      can = !fl && (!m_held || ordy);
      er  = '0;
      if (can && gr >= 0) er[gr] = 1'b1;
      chk("in_ready", 64'(in_ready), 64'(er[N-1:0]));
      if (fl) begin
        m_held = 1'b0;
      end else if (can && gr >= 0) begin
        m_held = 1'b1;
        if (RR != 0) m_ptr = gr;
        exp_q.push_back({8'(gr), dat[gr]});
        pushed = 1;
        acc_ch = gr;
      end else if (ordy) begin
        m_held = 1'b0;
      end
    endtask

    task automatic mid_reset();
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      exp_q.delete();
      pushed   = 0;
      m_held   = 1'b0;
      m_ptr    = N - 1;
      acc_ch   = -1;
      in_valid = '0;
      flush    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    endtask

    initial begin : drv
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      in_valid  = '0;
      for (int c = 0; c < 4; c++) dat[c] = $urandom;
      drive_data();
      m_ptr  = N - 1;
      m_held = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_ch", 64'(out_ch), 64'd0);
      rst_n = 1'b1;

      if (g == 0) begin
        repeat (5) cyc(4'b1111, 1'b1, 1'b0);
        acc_ch = -1;
        dat[2] = 32'hDEADBEEF;
        cyc(4'b0100, 1'b1, 1'b0);
        repeat (3) cyc(4'b1111, 1'b0, 1'b0);
        cyc(4'b1111, 1'b1, 1'b0);
        cyc(4'b0001, 1'b1, 1'b1);
        cyc(4'b0001, 1'b1, 1'b0);
        cyc(4'b1111, 1'b0, 1'b0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        mid_reset();
        repeat (2) cyc(4'b1001, 1'b1, 1'b0);
      end else if (g == 1) begin
        repeat (6) cyc(4'b1010, 1'b1, 1'b0);
      end else begin
        repeat (2) cyc(4'b0010, 1'b1, 1'b0);
        repeat (3) cyc(4'b0011, 1'b1, 1'b0);
      end

      for (int n = 0; n < 400; n++) begin
        cyc(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        if ($urandom_range(0, 99) == 0) mid_reset();
      end
      repeat (3) cyc(4'b0000, 1'b1, 1'b0);
      done = 1;
    end

    initial begin : mon
      int ev;
      forever begin
        @(negedge clk);
        #4;
        ev = ((exp_q.size() - pushed) > 0) ? 1 : 0;
        chk("out_valid", 64'(out_valid), 64'(ev));
        if (out_valid && ev != 0) begin
          chk("out_data", 64'(out_data), 64'(exp_q[0][31:0]));
          chk("out_ch", 64'(out_ch), 64'(exp_q[0][39:32]));
          if (flush || out_ready) void'(exp_q.pop_front());
        end
        pushed = 0;
      end
    end
  end

  initial begin
    fork
      begin
        wait (cfg[0].done && cfg[1].done && cfg[2].done);
      end
      begin
        #100000;
        tests++;
        fails++;
        $display("FAIL timeout: stimulus did not complete within time limit");
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_arb_mux.md
# ysyx_22041211_arb_mux

Parametrised N-channel arbitrated selector with a one-entry registered output, the sequential successor to the core's 2:1 source select. It accepts N valid/ready producers, such as LSU, CSR and ALU write-back candidates, and picks one per cycle by round-robin or fixed priority. It holds the winner in an output register until the downstream stage accepts it. Sits between execute-side producers and the write-back/commit stage.

## Interface
- DATA_LEN, 32, payload width per channel
- CH_NUM, 2, number of input channels (≥2)
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
- CH_W, derived = max(1, clog2(CH_NUM)), channel-index width (localparam, not overridable)

- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous kill of held output, no accept this cycle
- in_valid  in  CH_NUM  per-channel request
- in_data  in  CH_NUM*DATA_LEN  flattened payloads; channel i at [i*DATA_LEN +: DATA_LEN]
- in_ready  out  CH_NUM  one-hot or zero; high only on the granted channel
- out_valid  out  1  output register holds an item
- out_data  out  DATA_LEN  held payload
- out_ch  out  CH_W  index of the channel that produced out_data
- out_ready  in  1  downstream accepts when out_valid && out_ready

## Operation
- can_load = !flush && (!out_valid || out_ready).
- grant: when RR_MODE=1, the first i with in_valid[i], searching from (ptr+1) mod CH_NUM upward with wrap. When RR_MODE=0, the lowest i with in_valid[i].
- in_ready[grant] = can_load && |in_valid. All other in_ready bits are 0. in_ready may depend combinationally on in_valid, out_ready and flush.
- Load on can_load && |in_valid: out_valid←1, out_data←in_data[grant], out_ch←grant, ptr←grant (RR only).
- On out_valid && out_ready with no new load: out_valid←0. out_data and out_ch hold their last values.
- flush=1: out_valid←0, no load, ptr unchanged, in_ready all 0.
- ptr advances only on an actual transfer into the register. Requests that are not granted never move ptr.
- A producer must hold in_valid and in_data stable until in_ready. Dropping in_valid early is permitted; it is a retraction and nothing is registered for it.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, ptr=CH_NUM-1, so channel 0 has first priority. in_ready=0 while rst_n is low.
- Latency: input handshake in cycle t → out_valid visible in cycle t+1.
- Throughput: 1 item/cycle when out_ready is held high (simultaneous drain and load in the same cycle).
- Backpressure: out_valid && !out_ready → in_ready=0. The register holds with no data change.
- Simultaneous flush and out_ready: flush wins; the item is discarded. The sink must not count it, since out_valid falls next cycle.
- Reset mid-transfer: out_valid drops immediately (async). The pending item is lost; ptr returns to CH_NUM-1.
- Wrap-around: ptr=CH_NUM-1 searches 0,1,…,CH_NUM-1. A single requester always wins regardless of ptr.

## Structure
- The shared package/header ysyx_22041211_pkg provides the clog2 helper and the CH_W derivation rule. This block defines no shared typedefs.
- Sub-module ysyx_22041211_rr_pick: combinational picker with inputs req[CH_NUM], base ptr and mode, and outputs grant index and any_req. It is reusable for the future regfile write-port arbiter.
- The top level contains only the output register, ptr register and handshake logic.

## Test plan
- Reset, then CH_NUM=4, RR_MODE=1, all in_valid=4'b1111, out_ready=1 → out_ch sequence 0,1,2,3,0 on consecutive cycles, one item per cycle.
- RR_MODE=0, in_valid=4'b1010 held, out_ready=1 → out_ch=1 every cycle; channel 3 is never granted (documented starvation).
- Backpressure: load item 0xDEADBEEF from ch2, then hold out_ready=0 for 3 cycles → out_valid=1, out_data=0xDEADBEEF stable, in_ready=0 throughout, ptr stays 2.
- Flush while out_valid=1 and out_ready=1 with in_valid=4'b0001 → next cycle out_valid=0, ch0 not accepted (in_ready[0]=0), ptr unchanged.
- Assert rst_n=0 asynchronously mid-cycle with out_valid=1 → out_valid=0 before the next edge. After release, first grant is ch0 with in_valid=4'b1001.
- CH_NUM=2 defaults, single requester ch1 only, ptr=1 → ch1 granted (wrap search). Check out_ch width=1 and out_data=in_data[63:32].
